// File: rtl/halut_decoder_if.sv
// rtl/halut_decoder_if.sv - encoder-to-decoder code stream and result handshake
interface halut_decoder_if #(
  parameter int unsigned K        = 16,
  parameter int unsigned C        = 32,
  parameter int unsigned OutWidth = 16
);
  localparam int KAddrWidth = $clog2(K);
  localparam int CAddrWidth = $clog2(C);

  logic [CAddrWidth-1:0] c_addr;
  logic [KAddrWidth-1:0] k_addr;
  logic                  valid;
  logic [OutWidth-1:0]   result;
  logic                  result_valid;
  logic                  result_ready;

  modport master (
    output c_addr, k_addr, valid, result_ready,
    input  result, result_valid
  );

  modport slave (
    input  c_addr, k_addr, valid, result_ready,
    output result, result_valid
  );
endinterface

// File: rtl/halut_decoder.sv
// rtl/halut_decoder.sv - HALUT decoder: LUT lookup per codebook, accumulate C entries per result
// Optional output saturation: define HALUT_DECODER_SATURATE_EN (default wraps to OutWidth bits).
module halut_decoder #(
  parameter int unsigned K        = 16,
  parameter int unsigned C        = 32,
  parameter int unsigned LutWidth = 8,
  parameter int unsigned OutWidth = 16,
  localparam int KAddrWidth = $clog2(K),
  localparam int CAddrWidth = $clog2(C),
  localparam int AccWidth   = LutWidth + CAddrWidth + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [CAddrWidth+KAddrWidth-1:0] waddr_i,
  input  logic signed [LutWidth-1:0]       wdata_i,
  input  logic                             we_i,
  halut_decoder_if.slave                   bus,
  output logic                             overflow_o,
  output logic                             seq_err_o
);
  localparam int CntWidth  = CAddrWidth + 1;
  localparam int AddrWidth = CAddrWidth + KAddrWidth;
  // {c,k} addressing spans the full power-of-two space of both fields
  localparam int Depth     = 1 << AddrWidth;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                      state_q, state_d;
  logic signed [LutWidth-1:0]  lut_q [Depth];
  logic signed [LutWidth-1:0]  entry_q;
  logic                        valid_q;
  logic signed [AccWidth-1:0]  acc_q, acc_d, sum;
  logic [CntWidth-1:0]         cnt_q, cnt_d;
  logic [CAddrWidth-1:0]       exp_q;
  logic signed [OutWidth-1:0]  result_q, result_d, res_val;
  logic                        overflow_q, overflow_d, seq_err_q;
  logic                        done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) lut_q[i] <= '0;
    end else if (we_i) begin
      lut_q[waddr_i] <= wdata_i;
    end
  end

  // Lookup stage; a same-cycle write lands after this read, so old data is returned
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      entry_q   <= '0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      valid_q <= bus.valid;
      if (bus.valid) begin
        entry_q <= lut_q[{bus.c_addr, bus.k_addr}];
        if (bus.c_addr != exp_q) seq_err_q <= 1'b1;
        exp_q <= (exp_q == CAddrWidth'(C - 1)) ? '0 : exp_q + 1'b1;
      end
    end
  end

  assign sum  = acc_q + AccWidth'(entry_q);
  assign done = valid_q && (cnt_q == CntWidth'(C - 1));

`ifdef HALUT_DECODER_SATURATE_EN
  generate
    if (AccWidth > OutWidth) begin : g_sat
      localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
      localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;
      always_comb begin
        res_val = sum[OutWidth-1:0];
        if (sum > SatMax)      res_val = SatMax[OutWidth-1:0];
        else if (sum < SatMin) res_val = SatMin[OutWidth-1:0];
      end
    end else begin : g_ext
      assign res_val = OutWidth'(sum);
    end
  endgenerate
`else
  assign res_val = OutWidth'(sum);
`endif

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    if (valid_q) begin
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Accumulation never stalls; a completion while the old result is unaccepted is dropped
    if (done) begin
      if ((state_q == HOLD) && !bus.result_ready) begin
        overflow_d = 1'b1;
      end else begin
        result_d = res_val;
      end
      state_d = HOLD;
    end else if ((state_q != HOLD) || bus.result_ready) begin
      state_d = (cnt_d == '0) ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == HOLD);
  assign overflow_o       = overflow_q;
  assign seq_err_o        = seq_err_q;
endmodule

// File: tb/tb_halut_decoder.sv
// tb/tb_halut_decoder.sv - directed bench with result scoreboard for halut_decoder
module tb_halut_decoder;
  localparam int K = 16;
  localparam int C = 32;
  localparam int LutWidth = 8;
  localparam int OutWidth = 16;
  localparam int KA = 4;
  localparam int CA = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [CA+KA-1:0] waddr;
  logic signed [LutWidth-1:0] wdata;
  logic we;
  logic overflow, seq_err, overflow8, seq_err8;

  always #5 clk = ~clk;

  halut_decoder_if #(.K(K), .C(C), .OutWidth(OutWidth)) bus ();
  halut_decoder_if #(.K(K), .C(C), .OutWidth(8))        bus8 ();

  assign bus8.c_addr       = bus.c_addr;
  assign bus8.k_addr       = bus.k_addr;
  assign bus8.valid        = bus.valid;
  assign bus8.result_ready = bus.result_ready;

  halut_decoder #(.K(K), .C(C), .LutWidth(LutWidth), .OutWidth(OutWidth)) dut (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .bus(bus), .overflow_o(overflow), .seq_err_o(seq_err)
  );

  halut_decoder #(.K(K), .C(C), .LutWidth(LutWidth), .OutWidth(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .bus(bus8), .overflow_o(overflow8), .seq_err_o(seq_err8)
  );

  int n_asserts = 0;
  int n_fail = 0;
  int sb[$];
  int model[C][K];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.result_valid && bus.result_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        check("sb_result", $signed(bus.result), sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid = 1'b0;
    we = 1'b0;
    for (int c = 0; c < C; c++)
      for (int k = 0; k < K; k++) model[c][k] = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic fill(input int d_other, input int d_k3);
    for (int c = 0; c < C; c++) begin
      for (int k = 0; k < K; k++) begin
        int d;
        d = (k == 3) ? d_k3 : d_other;
        we = 1'b1;
        waddr = {c[CA-1:0], k[KA-1:0]};
        wdata = d[LutWidth-1:0];
        step();
        model[c][k] = d;
      end
    end
    we = 1'b0;
  endtask

  task automatic send_frame(input int kk, input bit push, input bit wr_c0 = 1'b0, input int wval = 0);
    int sum;
    int kc;
    sum = 0;
    for (int c = 0; c < C; c++) begin
      kc = (kk < 0) ? int'($urandom_range(0, K - 1)) : kk;
      bus.valid = 1'b1;
      bus.c_addr = c[CA-1:0];
      bus.k_addr = kc[KA-1:0];
      sum += model[c][kc];
      if (wr_c0 && c == 0) begin
        we = 1'b1;
        waddr = {{CA{1'b0}}, kc[KA-1:0]};
        wdata = wval[LutWidth-1:0];
      end
      step();
      if (wr_c0 && c == 0) begin
        we = 1'b0;
        model[0][kc] = wval;
      end
    end
    bus.valid = 1'b0;
    if (push) sb.push_back(sum);
  endtask

  initial begin
    int hold_exp;
    int exp8;
    rst_n = 1'b0;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    bus.valid = 1'b0;
    bus.c_addr = '0;
    bus.k_addr = '0;
    bus.result_ready = 1'b1;

    do_reset();
    check("reset_result_valid", bus.result_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_overflow", overflow, 0);
    check("reset_seq_err", seq_err, 0);

    // LUT comes out of reset as zeros
    send_frame(-1, 1'b1);
    step();
    step();

    fill(1, 1);
    send_frame(-1, 1'b1);
    check("ones_rv_before", bus.result_valid, 0);
    step();
    check("ones_rv_latency", bus.result_valid, 1);
    check("ones_dut8_result", bus8.result, 32);
    step();
    check("ones_single_result", bus.result_valid, 0);

    fill(5, -2);
    send_frame(3, 1'b1);
    send_frame(0, 1'b1, 1'b1, 9);
    send_frame(0, 1'b1);
    step();
    step();

    // Consumer stalls across two completions
    bus.result_ready = 1'b0;
    hold_exp = -2 * C;
    send_frame(3, 1'b1);
    step();
    check("hold_first_rv", bus.result_valid, 1);
    check("hold_no_overflow_yet", overflow, 0);
    send_frame(0, 1'b0);
    step();
    check("hold_overflow", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      check("hold_result_stable", $signed(bus.result), hold_exp);
      check("hold_rv_stable", bus.result_valid, 1);
      step();
    end
    bus.result_ready = 1'b1;
    step();
    check("hold_released", bus.result_valid, 0);
    check("hold_overflow_sticky", overflow, 1);

`ifdef HALUT_DECODER_SATURATE_EN
    exp8 = 127;
`else
    exp8 = 'hE0;
`endif
    fill(127, 127);
    send_frame(-1, 1'b1);
    step();
    check("narrow_rv", bus8.result_valid, 1);
    check("narrow_result", bus8.result, exp8);
    step();

    do_reset();
    check("reset_clears_overflow", overflow, 0);
    bus.valid = 1'b1;
    bus.k_addr = '0;
    bus.c_addr = 5'd0;
    step();
    bus.c_addr = 5'd1;
    step();
    check("seq_in_order", seq_err, 0);
    bus.c_addr = 5'd3;
    step();
    bus.valid = 1'b0;
    check("seq_err_set", seq_err, 1);
    step();
    step();
    step();
    check("seq_err_sticky", seq_err, 1);

    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.valid = 1'b1;
      bus.c_addr = c[CA-1:0];
      step();
    end
    bus.valid = 1'b0;
    do_reset();
    check("midreset_rv", bus.result_valid, 0);
    check("midreset_seq_err", seq_err, 0);
    fill(1, 1);
    send_frame(-1, 1'b1);
    step();
    step();
    check("midreset_seq_err_after", seq_err, 0);
    check("midreset_overflow_after", overflow, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
